adder_4bit: RTL and testbench
=============================

// Module: adder_4bit
// PURPOSE
//   Registered binary adder: computes {c_out, sum} = a + b + c_in and presents the result one clock later.
//   Intended as the basic arithmetic building block for datapaths that need a carry-in/carry-out chainable adder.
//   Internally a carry-lookahead structure (4-bit groups, generate/propagate), result captured in output registers.
// PARAMETERS
//   WIDTH    4   operand and sum width in bits; must be >= 1; lookahead groups of 4, last group may be partial
// PORTS
//   clk    in   1       rising-edge clock; all state updates on posedge clk
//   rst    in   1       synchronous, active-high reset
//   a      in   WIDTH   operand A, unsigned
//   b      in   WIDTH   operand B, unsigned
//   c_in   in   1       carry-in, weight 1
//   c_out  out  1       carry-out of the MSB, registered
//   sum    out  WIDTH   low WIDTH bits of a + b + c_in, registered
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is synchronous and active-high.
//   - Reset: on posedge clk with rst=1 -> sum=0, c_out=0; inputs ignored that cycle.
//   - Arithmetic: full result is WIDTH+1 bits, unsigned: {c_out,sum} = a + b + c_in; no saturation, modulo 2^WIDTH in sum.
//   - Latency: exactly 1 cycle; inputs sampled at posedge N appear on outputs after posedge N, held until next posedge.
//   - Throughput: one new operand set per cycle; no handshake, no valid/ready, no stall.
//   - Carry structure: per-bit g=a&b, p=a^b; group carries from lookahead equations; group carry-out
//     chains to next group; sum[i] = p[i] ^ carry[i]; c_out = carry out of the top group.
//   - Combinational path from inputs to register D only; no combinational input-to-output path.
//   - Boundaries: all-ones + 0 + c_in=1 wraps to sum=0, c_out=1; max case (all-ones + all-ones + 1) gives
//     sum=all-ones, c_out=1; X-free outputs after first reset.
//   - rst asserted mid-stream: outputs go to 0 at that edge; first result after rst deasserts reflects inputs
//     sampled at the first edge with rst=0.
//   - Before first reset outputs are undefined; benches must reset first.
// TESTING
//   1. rst=1 for 2 cycles, any inputs -> sum=0x0, c_out=0 after each edge.
//   2. a=0x0,b=0x0,c_in=0 -> next cycle sum=0x0, c_out=0.
//   3. a=0xF,b=0x1,c_in=0 -> sum=0x0, c_out=1 (wrap); a=0xF,b=0xF,c_in=1 -> sum=0xF, c_out=1.
//   4. a=0x5,b=0xA,c_in=1 -> sum=0x0, c_out=1 (full carry ripple across all groups).
//   5. Back-to-back: cycle N a=3,b=4,c_in=0; cycle N+1 a=8,b=8,c_in=1 -> sum 0x7/c_out 0 then 0x1/c_out 1, one cycle apart.
//   6. Exhaustive all 512 (a,b,c_in) combos plus random stream with rst pulsed mid-stream ->
//      {c_out,sum} == a+b+c_in one cycle later, zero while rst.

Source files
------------

// File: rtl/adder_4bit.sv
// Registered carry-lookahead adder: {c_out, sum} = a + b + c_in, one cycle latency.
// Lookahead is flattened inside 4-bit groups; group carries ripple between groups.

module adder_cla_grp #(
  parameter int GW = 4
) (
  input  logic [GW-1:0] g_i,
  input  logic [GW-1:0] p_i,
  input  logic          c_i,
  output logic [GW:0]   c_o
);
  logic term, pp;

  // Each carry is expanded directly from g/p/c_i so no carry depends on another carry.
  always_comb begin
    c_o    = '0;
    term   = 1'b0;
    pp     = 1'b0;
    c_o[0] = c_i;
    for (int i = 0; i < GW; i++) begin
      term = g_i[i];
      pp   = p_i[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g_i[j]);
        pp   = pp & p_i[j];
      end
      c_o[i+1] = term | (pp & c_i);
    end
  end
endmodule

module adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             c_out,
  output logic [WIDTH-1:0] sum
);
  localparam int NG = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] g, p, cbit;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             c_out_d, c_out_q;

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = c_in;

  // Top group is narrower when WIDTH is not a multiple of 4.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int LO = 4 * k;
    localparam int GW = ((WIDTH - LO) < 4) ? (WIDTH - LO) : 4;
    logic [GW:0] c;

    adder_cla_grp #(.GW(GW)) u_grp (
      .g_i (g[LO +: GW]),
      .p_i (p[LO +: GW]),
      .c_i (gc[k]),
      .c_o (c)
    );

    assign cbit[LO +: GW] = c[GW-1:0];
    assign gc[k+1]        = c[GW];
  end

  assign sum_d   = p ^ cbit;
  assign c_out_d = gc[NG];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
endmodule

// File: tb/tb_adder_4bit.sv
// Directed + exhaustive + random checks of adder_4bit against an arithmetic scoreboard.

module tb_adder_4bit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, sum;
  logic         c_in, c_out;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  adder_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .c_out (c_out),
    .sum   (sum)
  );

  // Drive one operand set mid-cycle, push its expected result, check after the next edge.
  task automatic step(input logic r, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input string tag);
    logic [W:0] e, obs;
    @(negedge clk);
    rst  = r;
    a    = ta;
    b    = tb;
    c_in = tc;
    if (r) exp_q.push_back('0);
    else   exp_q.push_back({1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc});
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    obs = {c_out, sum};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed {c_out,sum}=%h expected %h", tag, obs, e);
    end
  endtask

  initial begin
    rst  = 1'b1;
    a    = '0;
    b    = '0;
    c_in = 1'b0;

    step(1'b1, 4'hF, 4'hF, 1'b1, "reset0");
    step(1'b1, 4'hA, 4'h7, 1'b0, "reset1");

    step(1'b0, 4'h0, 4'h0, 1'b0, "zero");
    step(1'b0, 4'hF, 4'h1, 1'b0, "wrap");
    step(1'b0, 4'hF, 4'hF, 1'b1, "max");
    step(1'b0, 4'hF, 4'h0, 1'b1, "ones_plus_cin");
    step(1'b0, 4'h5, 4'hA, 1'b1, "ripple");
    step(1'b0, 4'h3, 4'h4, 1'b0, "b2b_first");
    step(1'b0, 4'h8, 4'h8, 1'b1, "b2b_second");

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step(1'b0, v[8:5], v[4:1], v[0], $sformatf("exh_%0d", i));
    end

    for (int i = 0; i < 200; i++) begin
      logic r;
      r = (i >= 60 && i < 63) || (i == 140);
      step(r, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
           $sformatf("rand_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
